cart_bank_mapper: RTL and testbench
===================================

Name: cart_bank_mapper

Overview:
Generic, parametrised bank-switching engine for MSX ROM cartridges. It replaces per-mapper combinational enables with one block that holds its own bank registers and handles Konami, Konami-SCC, ASCII8, ASCII16 and linear modes. The block sits between the slot decoder and the cartridge SDRAM/BRAM read path. It translates CPU addresses into ROM byte addresses, with an SCC window select.

Parameters:
ROM_AW, 21, ROM byte-address width (2 MB max)
BANK_W, 8, width of each bank register
NBANKS, 4, number of 8 KB bank registers (16 KB modes use the first NBANKS/2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  slot selected and cartridge present; writes are ignored and rom_oe=0 when low
mode  in  3  0=linear, 1=konami, 2=konami_scc, 3=ascii8, 4=ascii16, 5-7=none
rom_mask  in  BANK_W  8 KB-bank wrap mask (ROM size/8K - 1)
cpu_addr  in  16  Z80 address
cpu_din  in  8  Z80 write data
cpu_wr  in  1  write strobe (level, may last many clk)
cpu_rd  in  1  read strobe (level)
rom_addr  out  ROM_AW  registered ROM byte address
rom_oe  out  1  registered: read hits mapped ROM
scc_sel  out  1  registered: read hits SCC register window
bank_dbg  out  NBANKS*BANK_W  concatenated bank registers, bank0 in LSBs

Behaviour:
- Reset: rom_addr=0, rom_oe=0, scc_sel=0, scc_en=0, all banks at mode defaults. Reset has priority over every other event.
- Mode defaults:
  - konami / konami_scc: bank[i]=i
  - ascii8: all banks 0
  - ascii16: bank0=0, bank1=0
  - linear / none: don't-care; registers are cleared to 0
- Mode change: `mode` is registered internally. Any cycle where the registered mode differs from the input reloads the defaults on the next clk and clears scc_en. A write in that same cycle is dropped.
- Write commit:
  - A rising edge of (cpu_wr & en) commits exactly one bank write, one clk after the edge.
  - A held cpu_wr never writes twice.
  - cpu_wr deasserted then reasserted gives a new write.
- Write decode, konami: 6000-7FFF→bank1, 8000-9FFF→bank2, A000-BFFF→bank3. bank0 is fixed at 0.
- Write decode, konami_scc: 5000-57FF→b0, 7000-77FF→b1, 9000-97FF→b2, B000-B7FF→b3. A write to 9000-97FF also sets scc_en = (cpu_din[5:0]==6'h3F).
- Write decode, ascii8: 6000-67FF→b0, 6800-6FFF→b1, 7000-77FF→b2, 7800-7FFF→b3.
- Write decode, ascii16: 6000-67FF→b0, 7000-77FF→b1.
- Writes: the stored value is cpu_din[BANK_W-1:0] & rom_mask. For ascii16 the mask is applied as (rom_mask>>1). Writes outside the decoded ranges are ignored.
- Read translation, 8 KB modes:
  - Window 4000-BFFF; slot index s = cpu_addr[14:13]-2'd2 (mod 4).
  - rom_addr = {bank[s], cpu_addr[12:0]}, truncated/zero-extended to ROM_AW.
- Read translation, ascii16:
  - 4000-7FFF uses b0, 8000-BFFF uses b1.
  - rom_addr = {bank, cpu_addr[13:0]}.
- Read translation, linear: rom_addr = {cpu_addr} masked with {rom_mask,13'h1FFF}, over the full 0000-FFFF range.
- Output latency:
  - rom_oe/rom_addr/scc_sel are registered one clk after cpu_rd & en with a valid address; there is no combinational path.
  - rom_oe=0 outside the mapped window or when mode=none.
- SCC window:
  - scc_sel=1 when mode=konami_scc, scc_en=1, the read is in 9800-9FFF, and cpu_rd & en.
  - rom_oe=0 in that case.
- Simultaneous write and read: the read in the same clk uses the old bank value. The new value is visible from the following clk.
- en deasserted mid-write: the edge detector is cleared, so no commit happens. rom_oe and scc_sel drop on the next clk.

Test Plan:
- Reset, mode=konami, read 0xA123 → next clk rom_oe=1, rom_addr=0x06123 (bank3=3).
- konami, rom_mask=0x0F, write 0x8000←0x25, read 0x8001 → bank2=0x05, rom_addr=0x0A001. Holding cpu_wr 10 clk gives exactly one commit (check bank_dbg).
- konami_scc, write 0x9000←0x3F, read 0x9800 → scc_sel=1, rom_oe=0. Then write 0x9000←0x02, read 0x9800 → scc_sel=0, rom_oe=1, rom_addr=0x05800.
- ascii16, rom_mask=0x3F, write 0x7000←0x07, read 0xBFFF → rom_addr=0x1FFFF. Read 0x4000 → rom_addr=0x00000.
- ascii8, write 0x7800←0x11, then switch mode to konami without reset → bank_dbg returns to {3,2,1,0}; the read of 0xA000 maps to 0x06000.
- Write 0x6000 with en=0, and a read of 0x2000 in ascii8 → banks unchanged, rom_oe=0. Assert reset mid-write → all outputs 0 on the next clk.

Source files
------------

// File: rtl/cart_bank_mapper_if.sv
// Cartridge-side bus between the slot decoder and the bank mapper:
// CPU strobes, address/data, mapper configuration and the translated
// ROM read request.
interface cart_bank_mapper_if #(
  parameter int ROM_AW = 21,
  parameter int BANK_W = 8,
  parameter int NBANKS = 4
);
  logic                     en;
  logic [2:0]               mode;
  logic [BANK_W-1:0]        rom_mask;
  logic [15:0]              cpu_addr;
  logic [7:0]               cpu_din;
  logic                     cpu_wr;
  logic                     cpu_rd;
  logic [ROM_AW-1:0]        rom_addr;
  logic                     rom_oe;
  logic                     scc_sel;
  logic [NBANKS*BANK_W-1:0] bank_dbg;

  // Slot decoder / CPU side: drives strobes and configuration.
  modport master (
    output en, mode, rom_mask, cpu_addr, cpu_din, cpu_wr, cpu_rd,
    input  rom_addr, rom_oe, scc_sel, bank_dbg
  );

  // Mapper side: consumes strobes, produces the ROM read request.
  modport slave (
    input  en, mode, rom_mask, cpu_addr, cpu_din, cpu_wr, cpu_rd,
    output rom_addr, rom_oe, scc_sel, bank_dbg
  );
endinterface

// File: rtl/cart_bank_mapper.sv
// MSX ROM cartridge bank-switching engine. Holds the bank registers for
// Konami, Konami-SCC, ASCII8, ASCII16 and linear layouts, commits one bank
// write per rising write strobe, and translates CPU reads into registered
// ROM byte addresses (or an SCC register-window select).
// Bank-write decode targets indices 0..3, so NBANKS must be at least 4.
module cart_bank_mapper #(
  parameter int ROM_AW = 21,
  parameter int BANK_W = 8,
  parameter int NBANKS = 4
) (
  input logic              clk,
  input logic              reset,
  cart_bank_mapper_if.slave bus
);

  localparam logic [2:0] MODE_LINEAR     = 3'd0;
  localparam logic [2:0] MODE_KONAMI     = 3'd1;
  localparam logic [2:0] MODE_KONAMI_SCC = 3'd2;
  localparam logic [2:0] MODE_ASCII8     = 3'd3;
  localparam logic [2:0] MODE_ASCII16    = 3'd4;

  typedef logic [NBANKS-1:0][BANK_W-1:0] bank_vec_t;

  // Konami layouts power up as an identity map; every other mode clears.
  function automatic bank_vec_t mode_defaults(input logic [2:0] m);
    bank_vec_t v;
    v = '0;
    if (m == MODE_KONAMI || m == MODE_KONAMI_SCC) begin
      for (int i = 0; i < NBANKS; i++) begin
        v[i] = BANK_W'(i);
      end
    end else begin
      v = '0;
    end
    return v;
  endfunction

  bank_vec_t         bank;
  logic [2:0]        mode_q;
  logic              scc_en;
  logic              wr_prev;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_oe;
  logic              scc_sel;

  logic              wr_rise;
  logic              wr_hit;
  logic [1:0]        wr_idx;
  logic [BANK_W-1:0] wr_val;
  logic              scc_upd;
  logic              scc_val;
  logic              mode_chg;

  logic              rd_hit;
  logic              in_8k_win;
  logic [1:0]        rd_slot;
  logic              rom_oe_next;
  logic              scc_sel_next;
  logic [ROM_AW-1:0] rom_addr_next;

  assign wr_rise  = bus.cpu_wr & bus.en & ~wr_prev;
  assign mode_chg = (mode_q != bus.mode);
  assign scc_val  = (bus.cpu_din[5:0] == 6'h3F);
  assign rd_hit   = bus.cpu_rd & bus.en;
  assign in_8k_win = (bus.cpu_addr[15:14] == 2'b01) || (bus.cpu_addr[15:14] == 2'b10);
  assign rd_slot  = bus.cpu_addr[14:13] - 2'd2;

  // Decode which bank register (if any) a CPU write targets in the current mode.
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = 2'd0;
    scc_upd = 1'b0;
    wr_val  = BANK_W'(bus.cpu_din) & bus.rom_mask;
    case (mode_q)
      MODE_KONAMI: begin
        case (bus.cpu_addr[15:13])
          3'b011:  begin wr_hit = 1'b1; wr_idx = 2'd1; end
          3'b100:  begin wr_hit = 1'b1; wr_idx = 2'd2; end
          3'b101:  begin wr_hit = 1'b1; wr_idx = 2'd3; end
          default: wr_hit = 1'b0;
        endcase
      end
      MODE_KONAMI_SCC: begin
        case (bus.cpu_addr[15:11])
          5'b01010: begin wr_hit = 1'b1; wr_idx = 2'd0; end
          5'b01110: begin wr_hit = 1'b1; wr_idx = 2'd1; end
          5'b10010: begin wr_hit = 1'b1; wr_idx = 2'd2; scc_upd = 1'b1; end
          5'b10110: begin wr_hit = 1'b1; wr_idx = 2'd3; end
          default:  wr_hit = 1'b0;
        endcase
      end
      MODE_ASCII8: begin
        case (bus.cpu_addr[15:11])
          5'b01100: begin wr_hit = 1'b1; wr_idx = 2'd0; end
          5'b01101: begin wr_hit = 1'b1; wr_idx = 2'd1; end
          5'b01110: begin wr_hit = 1'b1; wr_idx = 2'd2; end
          5'b01111: begin wr_hit = 1'b1; wr_idx = 2'd3; end
          default:  wr_hit = 1'b0;
        endcase
      end
      MODE_ASCII16: begin
        // 16 KB banks: the 8 KB wrap mask is halved.
        wr_val = BANK_W'(bus.cpu_din) & (bus.rom_mask >> 1);
        case (bus.cpu_addr[15:11])
          5'b01100: begin wr_hit = 1'b1; wr_idx = 2'd0; end
          5'b01110: begin wr_hit = 1'b1; wr_idx = 2'd1; end
          default:  wr_hit = 1'b0;
        endcase
      end
      default: wr_hit = 1'b0;
    endcase
  end

  // Translate the CPU read address into a ROM address or SCC window hit.
  always_comb begin
    rom_oe_next   = 1'b0;
    scc_sel_next  = 1'b0;
    rom_addr_next = rom_addr;
    if (rd_hit) begin
      case (mode_q)
        MODE_LINEAR: begin
          rom_oe_next   = 1'b1;
          rom_addr_next = ROM_AW'(bus.cpu_addr) & ROM_AW'({bus.rom_mask, 13'h1FFF});
        end
        MODE_KONAMI, MODE_KONAMI_SCC, MODE_ASCII8: begin
          if (in_8k_win) begin
            if (mode_q == MODE_KONAMI_SCC && scc_en && bus.cpu_addr[15:11] == 5'b10011) begin
              scc_sel_next = 1'b1;
            end else begin
              rom_oe_next   = 1'b1;
              rom_addr_next = ROM_AW'({bank[rd_slot], bus.cpu_addr[12:0]});
            end
          end else begin
            rom_oe_next = 1'b0;
          end
        end
        MODE_ASCII16: begin
          if (in_8k_win) begin
            rom_oe_next   = 1'b1;
            rom_addr_next = ROM_AW'({bank[bus.cpu_addr[15] ? 1 : 0], bus.cpu_addr[13:0]});
          end else begin
            rom_oe_next = 1'b0;
          end
        end
        default: rom_oe_next = 1'b0;
      endcase
    end else begin
      rom_oe_next = 1'b0;
    end
  end

  // Bank/mode state, write-edge detector and registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= bus.mode;
      bank     <= mode_defaults(bus.mode);
      scc_en   <= 1'b0;
      wr_prev  <= 1'b0;
      rom_addr <= '0;
      rom_oe   <= 1'b0;
      scc_sel  <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      wr_prev <= bus.cpu_wr & bus.en;
      if (mode_chg) begin
        // A mode switch wins over any write landing in the same cycle.
        bank   <= mode_defaults(bus.mode);
        scc_en <= 1'b0;
      end else if (wr_rise && wr_hit) begin
        bank[wr_idx] <= wr_val;
        if (scc_upd) begin
          scc_en <= scc_val;
        end else begin
          scc_en <= scc_en;
        end
      end else begin
        bank   <= bank;
        scc_en <= scc_en;
      end
      rom_addr <= rom_addr_next;
      rom_oe   <= rom_oe_next;
      scc_sel  <= scc_sel_next;
    end
  end

  assign bus.rom_addr = rom_addr;
  assign bus.rom_oe   = rom_oe;
  assign bus.scc_sel  = scc_sel;
  assign bus.bank_dbg = bank;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed bench for cart_bank_mapper: hand-computed ROM addresses, bank
// register contents and SCC window selects across all mapper modes.
module tb_cart_bank_mapper;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cart_bank_mapper_if #(.ROM_AW(21), .BANK_W(8), .NBANKS(4)) bus ();

  cart_bank_mapper #(.ROM_AW(21), .BANK_W(8), .NBANKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    bus.cpu_wr   = 1'b1;
    tick();
    bus.cpu_wr   = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [15:0] a);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    tick();
    bus.cpu_rd   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.mode     = 3'd1;
    bus.rom_mask = 8'hFF;
    bus.cpu_addr = 16'h0000;
    bus.cpu_din  = 8'h00;
    bus.cpu_wr   = 1'b0;
    bus.cpu_rd   = 1'b0;
    tick();
    tick();
    check("rst_oe",   64'(bus.rom_oe),   64'h0);
    check("rst_addr", 64'(bus.rom_addr), 64'h0);
    check("rst_scc",  64'(bus.scc_sel),  64'h0);
    check("rst_bank", 64'(bus.bank_dbg), 64'h03020100);
    reset = 1'b0;

    // Konami identity map: A123 through bank3.
    rd(16'hA123);
    check("kon_oe",   64'(bus.rom_oe),   64'h1);
    check("kon_addr", 64'(bus.rom_addr), 64'h06123);

    // Write and read in the same clock: read sees the old bank1.
    bus.cpu_addr = 16'h6000;
    bus.cpu_din  = 8'h09;
    bus.cpu_wr   = 1'b1;
    bus.cpu_rd   = 1'b1;
    tick();
    check("simul_old", 64'(bus.rom_addr), 64'h02000);
    bus.cpu_wr = 1'b0;
    tick();
    check("simul_new", 64'(bus.rom_addr), 64'h12000);
    bus.cpu_rd = 1'b0;
    tick();

    // Masked write and held strobe committing once.
    bus.rom_mask = 8'h0F;
    bus.cpu_addr = 16'h8000;
    bus.cpu_din  = 8'h25;
    bus.cpu_wr   = 1'b1;
    tick();
    check("hold_first", 64'(bus.bank_dbg), 64'h03050900);
    bus.cpu_din = 8'h07;
    repeat (9) tick();
    check("hold_once", 64'(bus.bank_dbg), 64'h03050900);
    bus.cpu_wr = 1'b0;
    tick();
    rd(16'h8001);
    check("mask_addr", 64'(bus.rom_addr), 64'h0A001);
    wr(16'h8000, 8'h07);
    check("rewrite", 64'(bus.bank_dbg), 64'h03070900);

    // Konami-SCC: mode reload and SCC window enable/disable.
    bus.mode     = 3'd2;
    bus.rom_mask = 8'hFF;
    tick();
    check("scc_defaults", 64'(bus.bank_dbg), 64'h03020100);
    wr(16'h9000, 8'h3F);
    rd(16'h9800);
    check("scc_sel_on", 64'(bus.scc_sel), 64'h1);
    check("scc_oe_off", 64'(bus.rom_oe),  64'h0);
    wr(16'h9000, 8'h02);
    rd(16'h9800);
    check("scc_sel_off", 64'(bus.scc_sel),  64'h0);
    check("scc_oe_on",   64'(bus.rom_oe),   64'h1);
    check("scc_addr",    64'(bus.rom_addr), 64'h05800);

    // ASCII16 with halved mask.
    bus.mode     = 3'd4;
    bus.rom_mask = 8'h3F;
    tick();
    wr(16'h7000, 8'h07);
    rd(16'hBFFF);
    check("a16_hi", 64'(bus.rom_addr), 64'h1FFFF);
    rd(16'h4000);
    check("a16_lo", 64'(bus.rom_addr), 64'h00000);
    wr(16'h6000, 8'h25);
    rd(16'h4000);
    check("a16_mask", 64'(bus.rom_addr), 64'h14000);
    check("a16_bank", 64'(bus.bank_dbg), 64'h00000705);

    // Mode change drops a write in the same cycle.
    bus.rom_mask = 8'hFF;
    bus.mode     = 3'd3;
    bus.cpu_addr = 16'h6000;
    bus.cpu_din  = 8'h33;
    bus.cpu_wr   = 1'b1;
    tick();
    bus.cpu_wr = 1'b0;
    tick();
    check("mode_chg_drop", 64'(bus.bank_dbg), 64'h0);
    wr(16'h7800, 8'h11);
    check("a8_b3", 64'(bus.bank_dbg), 64'h11000000);
    bus.mode = 3'd1;
    tick();
    check("to_konami", 64'(bus.bank_dbg), 64'h03020100);
    rd(16'hA000);
    check("to_konami_addr", 64'(bus.rom_addr), 64'h06000);

    // ASCII8: disabled write, out-of-window read, reset mid-write.
    bus.mode = 3'd3;
    tick();
    bus.en = 1'b0;
    wr(16'h6000, 8'h44);
    bus.en = 1'b1;
    check("en_off_wr", 64'(bus.bank_dbg), 64'h0);
    rd(16'h2000);
    check("a8_oob_oe", 64'(bus.rom_oe), 64'h0);
    wr(16'h6800, 8'h0A);
    rd(16'h7000);
    check("a8_oe",   64'(bus.rom_oe),   64'h1);
    check("a8_addr", 64'(bus.rom_addr), 64'h15000);
    bus.cpu_addr = 16'h7000;
    bus.cpu_din  = 8'h55;
    bus.cpu_wr   = 1'b1;
    bus.cpu_rd   = 1'b1;
    reset        = 1'b1;
    tick();
    check("rstw_oe",   64'(bus.rom_oe),   64'h0);
    check("rstw_addr", 64'(bus.rom_addr), 64'h0);
    check("rstw_scc",  64'(bus.scc_sel),  64'h0);
    check("rstw_bank", 64'(bus.bank_dbg), 64'h0);
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
    reset      = 1'b0;
    tick();

    // Linear masking and the "none" mode.
    bus.mode     = 3'd0;
    bus.rom_mask = 8'h03;
    tick();
    rd(16'hC123);
    check("lin_oe",   64'(bus.rom_oe),   64'h1);
    check("lin_addr", 64'(bus.rom_addr), 64'h04123);
    bus.mode = 3'd5;
    tick();
    rd(16'h4000);
    check("none_oe", 64'(bus.rom_oe), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
